// File: rtl/wb_burst_master_if.sv
// Wishbone classic bus bundle between the burst master and its slave.
// Signal names follow the master's view of the bus.
interface wb_burst_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;

    logic [AW-1:0] ADR_O;
    logic [DW-1:0] DAT_O;
    logic [DW-1:0] DAT_I;
    logic [SW-1:0] SEL_O;
    logic          CYC_O;
    logic          STB_O;
    logic          WE_O;
    logic          ACK_I;
    logic          ERR_I;
    logic          RTY_I;

    modport master (
        output ADR_O, DAT_O, SEL_O, CYC_O, STB_O, WE_O,
        input  DAT_I, ACK_I, ERR_I, RTY_I
    );

    modport slave (
        input  ADR_O, DAT_O, SEL_O, CYC_O, STB_O, WE_O,
        output DAT_I, ACK_I, ERR_I, RTY_I
    );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone classic burst master: valid/ready command port, streamed write and
// read data, bounded RTY re-issue, strobe timeout and per-command status.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// WDATA  | CYC held, waiting for the next write beat
// STROBE | STB high, waiting for ACK/ERR/RTY or timeout
// GAP    | one idle-strobe cycle between read beats, CYC held
// RETRY  | CYC dropped for RETRY_GAP cycles before re-issuing the beat
// DONE   | rsp_valid pulse, bus released
module wb_burst_master #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LENW      = 4,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic              CLK_I,
    input  logic              RSTN_I,
    wb_burst_master_if.master wb,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [AW-1:0]     cmd_adr,
    input  logic [LENW-1:0]   cmd_len,
    input  logic              wdat_valid,
    output logic              wdat_ready,
    input  logic [DW-1:0]     wdat,
    input  logic [DW/8-1:0]   wsel,
    output logic              rdat_valid,
    output logic [DW-1:0]     rdat,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [LENW:0]     rsp_count
);
    localparam int SW = DW / 8;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(RETRY_GAP - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);
    localparam logic [AW-1:0] ADR_STEP = AW'(SW);

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WDATA  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_RETRY  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]      state;
    logic            we_q;
    logic [LENW-1:0] len_q;
    logic [LENW:0]   beat_cnt;
    logic [RW-1:0]   retry_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [GW-1:0]   gap_cnt;

    logic            last_beat;
    logic            retry_ok;
    logic            tmo_hit;
    logic            fin;
    logic [1:0]      fin_status;
    logic [LENW:0]   fin_count;

    assign last_beat = (beat_cnt == {1'b0, len_q});
    assign retry_ok  = (retry_cnt < RTY_MAX);
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == '0);

    // Termination decode while strobing; ERR beats RTY beats ACK.
    always_comb begin
        fin        = 1'b0;
        fin_status = ST_OK;
        fin_count  = beat_cnt;
        if (state == S_STROBE) begin
            if (wb.ERR_I) begin
                fin        = 1'b1;
                fin_status = ST_ERR;
            end else if (wb.RTY_I) begin
                if (!retry_ok) begin
                    fin        = 1'b1;
                    fin_status = ST_RTY;
                end
            end else if (wb.ACK_I) begin
                fin       = last_beat;
                fin_count = beat_cnt + 1'b1;
            end else if (tmo_hit) begin
                fin        = 1'b1;
                fin_status = ST_TMO;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            len_q      <= '0;
            beat_cnt   <= '0;
            retry_cnt  <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            wb.ADR_O   <= '0;
            wb.DAT_O   <= '0;
            wb.SEL_O   <= '0;
            wb.CYC_O   <= 1'b0;
            wb.STB_O   <= 1'b0;
            wb.WE_O    <= 1'b0;
            cmd_ready  <= 1'b0;
            wdat_ready <= 1'b0;
            rdat_valid <= 1'b0;
            rdat       <= '0;
            rsp_valid  <= 1'b0;
            rsp_status <= '0;
            rsp_count  <= '0;
        end else begin
            rdat_valid <= 1'b0;
            rsp_valid  <= 1'b0;
            tmo_cnt    <= TMO_LOAD;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        we_q      <= cmd_we;
                        len_q     <= cmd_len;
                        beat_cnt  <= '0;
                        retry_cnt <= '0;
                        wb.ADR_O  <= cmd_adr;
                        wb.WE_O   <= cmd_we;
                        wb.CYC_O  <= 1'b1;
                        if (cmd_we) begin
                            wdat_ready <= 1'b1;
                            state      <= S_WDATA;
                        end else begin
                            wb.SEL_O <= '1;
                            wb.STB_O <= 1'b1;
                            state    <= S_STROBE;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_WDATA: begin
                    if (wdat_valid) begin
                        wdat_ready <= 1'b0;
                        wb.DAT_O   <= wdat;
                        wb.SEL_O   <= wsel;
                        wb.STB_O   <= 1'b1;
                        state      <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (wb.ERR_I) begin
                        wb.STB_O <= 1'b0;
                    end else if (wb.RTY_I) begin
                        wb.CYC_O <= 1'b0;
                        wb.STB_O <= 1'b0;
                        if (retry_ok) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            gap_cnt   <= GAP_LOAD;
                            state     <= S_RETRY;
                        end
                    end else if (wb.ACK_I) begin
                        beat_cnt  <= beat_cnt + 1'b1;
                        retry_cnt <= '0;
                        wb.STB_O  <= 1'b0;
                        if (!we_q) begin
                            rdat       <= wb.DAT_I;
                            rdat_valid <= 1'b1;
                        end
                        if (!last_beat) begin
                            wb.ADR_O <= wb.ADR_O + ADR_STEP;
                            if (we_q) begin
                                wdat_ready <= 1'b1;
                                state      <= S_WDATA;
                            end else begin
                                state <= S_GAP;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    wb.STB_O <= 1'b1;
                    state    <= S_STROBE;
                end
                S_RETRY: begin
                    if (gap_cnt == '0) begin
                        wb.CYC_O <= 1'b1;
                        wb.STB_O <= 1'b1;
                        state    <= S_STROBE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (fin) begin
                wb.CYC_O   <= 1'b0;
                wb.STB_O   <= 1'b0;
                wb.WE_O    <= 1'b0;
                rsp_valid  <= 1'b1;
                rsp_status <= fin_status;
                rsp_count  <= fin_count;
                state      <= S_DONE;
            end
        end
    end
endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: a vector table of whole commands run
// against a scripted slave, plus hand-written reset sequences.
module tb_wb_burst_master;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = 4;
    localparam int LENW = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_burst_master_if #(.AW(AW), .DW(DW)) wb1 ();
    wb_burst_master_if #(.AW(AW), .DW(DW)) wb2 ();

    logic          ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [DW-1:0] dat_in = '0;
    assign wb1.ACK_I = ack;  assign wb2.ACK_I = ack;
    assign wb1.ERR_I = err;  assign wb2.ERR_I = err;
    assign wb1.RTY_I = rty;  assign wb2.RTY_I = rty;
    assign wb1.DAT_I = dat_in; assign wb2.DAT_I = dat_in;

    bit            sel2 = 1'b0;
    logic          cmd_valid = 1'b0, cmd_we = 1'b0, wdat_valid = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [LENW-1:0] cmd_len = '0;
    logic [DW-1:0] wdat = '0;
    logic [SW-1:0] wsel = '0;

    logic cmd_valid1, cmd_valid2, wdat_valid1, wdat_valid2;
    assign cmd_valid1  = cmd_valid & ~sel2;
    assign cmd_valid2  = cmd_valid & sel2;
    assign wdat_valid1 = wdat_valid & ~sel2;
    assign wdat_valid2 = wdat_valid & sel2;

    logic cmd_ready1, cmd_ready2, wdat_ready1, wdat_ready2;
    logic rdat_valid1, rdat_valid2, rsp_valid1, rsp_valid2;
    logic [DW-1:0] rdat1, rdat2;
    logic [1:0] rsp_status1, rsp_status2;
    logic [LENW:0] rsp_count1, rsp_count2;

    wb_burst_master #(.AW(AW), .DW(DW), .LENW(LENW), .MAX_RETRY(3),
                      .RETRY_GAP(2), .TIMEOUT(8)) dut1 (
        .CLK_I(clk), .RSTN_I(rstn), .wb(wb1.master),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid1), .wdat_ready(wdat_ready1), .wdat(wdat), .wsel(wsel),
        .rdat_valid(rdat_valid1), .rdat(rdat1),
        .rsp_valid(rsp_valid1), .rsp_status(rsp_status1), .rsp_count(rsp_count1)
    );

    wb_burst_master #(.AW(AW), .DW(DW), .LENW(LENW), .MAX_RETRY(1),
                      .RETRY_GAP(2), .TIMEOUT(8)) dut2 (
        .CLK_I(clk), .RSTN_I(rstn), .wb(wb2.master),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_len(cmd_len),
        .wdat_valid(wdat_valid2), .wdat_ready(wdat_ready2), .wdat(wdat), .wsel(wsel),
        .rdat_valid(rdat_valid2), .rdat(rdat2),
        .rsp_valid(rsp_valid2), .rsp_status(rsp_status2), .rsp_count(rsp_count2)
    );

    logic m_cyc, m_stb, m_we, m_cmd_ready, m_wdat_ready, m_rdat_valid, m_rsp_valid;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat, m_rdat;
    logic [SW-1:0] m_sel;
    logic [1:0] m_status;
    logic [LENW:0] m_count;
    assign m_cyc        = sel2 ? wb2.CYC_O : wb1.CYC_O;
    assign m_stb        = sel2 ? wb2.STB_O : wb1.STB_O;
    assign m_we         = sel2 ? wb2.WE_O  : wb1.WE_O;
    assign m_adr        = sel2 ? wb2.ADR_O : wb1.ADR_O;
    assign m_dat        = sel2 ? wb2.DAT_O : wb1.DAT_O;
    assign m_sel        = sel2 ? wb2.SEL_O : wb1.SEL_O;
    assign m_cmd_ready  = sel2 ? cmd_ready2 : cmd_ready1;
    assign m_wdat_ready = sel2 ? wdat_ready2 : wdat_ready1;
    assign m_rdat_valid = sel2 ? rdat_valid2 : rdat_valid1;
    assign m_rdat       = sel2 ? rdat2 : rdat1;
    assign m_rsp_valid  = sel2 ? rsp_valid2 : rsp_valid1;
    assign m_status     = sel2 ? rsp_status2 : rsp_status1;
    assign m_count      = sel2 ? rsp_count2 : rsp_count1;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endfunction

    // Write beat i carries base*(i+1); read beat i returns base+i.
    typedef struct {
        bit          d2;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  len;
        logic [31:0] base;
        logic [3:0]  sel;
        int          wgap;
        int          ack_dly;
        int          err_beat;
        int          rty_beat;
        int          rty_n;
        logic [1:0]  e_status;
        int          e_count;
        int          e_rdn;
        int          e_cyclow;
        int          e_stbmax;
        int          e_cychi;
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input int idx, input vec_t v);
        int acked = 0, wbeat = 0, wwait = 0, stbc = 0, stbmax = 0, rdn = 0;
        int cyclow = 0, cychi = 0, rty_done = 0, cyc_n = 0, last_rd = -1, rsp_at = 0, wt = 0;
        bit done = 1'b0;
        logic [1:0] st = '0;
        logic [LENW:0] cnt = '0;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;

        sel2    = v.d2;
        cmd_we  = v.we;
        cmd_adr = v.adr;
        cmd_len = v.len;
        while (!m_cmd_ready && wt < 20) begin
            @(negedge clk);
            wt++;
        end
        chk($sformatf("v%0d cmd_ready idle", idx), 64'(m_cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk($sformatf("v%0d cmd_ready busy", idx), 64'(m_cmd_ready), 64'd0);
        chk($sformatf("v%0d cyc after accept", idx), 64'(m_cyc), 64'd1);

        while (!done && cyc_n < 200) begin
            ack = 1'b0; err = 1'b0; rty = 1'b0; wdat_valid = 1'b0;
            if (m_rdat_valid) begin
                e_dat = v.base + DW'(rdn);
                chk($sformatf("v%0d rdat[%0d]", idx, rdn), 64'(m_rdat), 64'(e_dat));
                rdn++;
                last_rd = cyc_n;
            end
            if (m_rsp_valid) begin
                st     = m_status;
                cnt    = m_count;
                rsp_at = cyc_n;
                done   = 1'b1;
                chk($sformatf("v%0d cmd_ready in done", idx), 64'(m_cmd_ready), 64'd0);
                chk($sformatf("v%0d cyc in done", idx), 64'(m_cyc), 64'd0);
            end else begin
                if (m_cyc) cychi++;
                else cyclow++;
                if (m_wdat_ready) begin
                    if (wwait < v.wgap) wwait++;
                    else begin
                        wdat_valid = 1'b1;
                        wdat  = v.base * DW'(wbeat + 1);
                        wsel  = v.sel;
                        wbeat++;
                        wwait = 0;
                    end
                end
                if (m_stb) begin
                    stbc++;
                    if (stbc > stbmax) stbmax = stbc;
                    if (stbc == 1) begin
                        e_adr = v.adr + AW'(SW * acked);
                        chk($sformatf("v%0d adr beat%0d", idx, acked), 64'(m_adr), 64'(e_adr));
                        chk($sformatf("v%0d we beat%0d", idx, acked), 64'(m_we), 64'(v.we));
                        chk($sformatf("v%0d sel beat%0d", idx, acked), 64'(m_sel),
                            64'(v.we ? v.sel : 4'hF));
                        if (v.we) begin
                            e_dat = v.base * DW'(acked + 1);
                            chk($sformatf("v%0d dat beat%0d", idx, acked), 64'(m_dat), 64'(e_dat));
                        end
                    end
                    if (stbc == v.ack_dly) begin
                        if (acked == v.err_beat) begin
                            err = 1'b1; ack = 1'b1; dat_in = '1;
                        end else if (acked == v.rty_beat && rty_done < v.rty_n) begin
                            rty = 1'b1;
                            rty_done++;
                        end else begin
                            ack = 1'b1;
                            dat_in = v.base + DW'(acked);
                            acked++;
                        end
                    end
                end else begin
                    stbc = 0;
                end
            end
            @(negedge clk);
            cyc_n++;
        end
        ack = 1'b0; err = 1'b0; rty = 1'b0; wdat_valid = 1'b0;

        chk($sformatf("v%0d rsp seen", idx), 64'(done), 64'd1);
        chk($sformatf("v%0d status", idx), 64'(st), 64'(v.e_status));
        chk($sformatf("v%0d count", idx), 64'(cnt), 64'(v.e_count));
        chk($sformatf("v%0d rdat beats", idx), 64'(rdn), 64'(v.e_rdn));
        chk($sformatf("v%0d cyc low cycles", idx), 64'(cyclow), 64'(v.e_cyclow));
        chk($sformatf("v%0d cyc high cycles", idx), 64'(cychi), 64'(v.e_cychi));
        chk($sformatf("v%0d stb max run", idx), 64'(stbmax), 64'(v.e_stbmax));
        chk($sformatf("v%0d rsp after rdat", idx), 64'(rsp_at >= last_rd), 64'd1);
        chk($sformatf("v%0d rsp one pulse", idx), 64'(m_rsp_valid), 64'd0);
        chk($sformatf("v%0d ready after done", idx), 64'(m_cmd_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, acks;

        //       d2 we adr            len   base          sel  wg dly err rtyb rtyn st     cnt rdn low smax hi
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 4'd0,  32'hDEAD_BEEF, 4'hF, 0, 2, -1, -1, 0, 2'b00, 1,  1,  0, 2, 2};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_1000, 4'd3,  32'h0000_0011, 4'hF, 3, 1, -1, -1, 0, 2'b00, 4,  0,  0, 1, 20};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_2000, 4'd3,  32'h0000_0100, 4'hF, 0, 1, -1,  1, 2, 2'b00, 4,  0,  4, 1, 10};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_3000, 4'd3,  32'hC000_0000, 4'hF, 0, 1,  2, -1, 0, 2'b01, 2,  2,  0, 1, 5};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_4000, 4'd0,  32'h0000_0000, 4'hF, 0, 0, -1, -1, 0, 2'b11, 0,  0,  0, 8, 8};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 4'd1,  32'h0000_5000, 4'hF, 0, 1, -1, -1, 0, 2'b00, 2,  2,  0, 1, 3};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_6000, 4'd1,  32'h0000_6000, 4'hF, 0, 1, -1,  0, 4, 2'b10, 0,  0,  6, 1, 4};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_7000, 4'd3,  32'h0000_0007, 4'h3, 0, 1, -1,  1, 2, 2'b10, 1,  0,  2, 1, 5};
        vecs[8] = '{1'b0, 1'b1, 32'h0000_8000, 4'd0,  32'h0000_0008, 4'hC, 1, 3, -1, -1, 0, 2'b00, 1,  0,  0, 3, 5};
        vecs[9] = '{1'b0, 1'b0, 32'h0000_9000, 4'd15, 32'h0000_9000, 4'hF, 0, 1, -1, -1, 0, 2'b00, 16, 16, 0, 1, 31};

        @(negedge clk);
        @(negedge clk);
        chk("reset cyc", 64'(wb1.CYC_O), 64'd0);
        chk("reset stb", 64'(wb1.STB_O), 64'd0);
        chk("reset adr", 64'(wb1.ADR_O), 64'd0);
        chk("reset cmd_ready", 64'(cmd_ready1), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid1), 64'd0);
        chk("reset rsp_count", 64'(rsp_count1), 64'd0);
        chk("reset dut2 cyc", 64'(wb2.CYC_O), 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post reset cmd_ready", 64'(cmd_ready1), 64'd1);
        chk("post reset dut2 cmd_ready", 64'(cmd_ready2), 64'd1);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset asserted between edges while beat 2 of a read burst is strobing.
        sel2    = 1'b0;
        cmd_we  = 1'b0;
        cmd_adr = 32'h0000_A000;
        cmd_len = 4'd3;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        acks = 0;
        while (n < 20 && !(m_stb && acks == 1)) begin
            ack = 1'b0;
            if (m_stb) begin
                ack = 1'b1;
                dat_in = 32'h1234_0000;
                acks++;
            end
            @(negedge clk);
            n++;
        end
        ack = 1'b0;
        chk("rst_mid beat2 strobing", 64'(m_stb), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid cyc immediate", 64'(wb1.CYC_O), 64'd0);
        chk("rst_mid stb immediate", 64'(wb1.STB_O), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid no rsp %0d", k), 64'(rsp_valid1), 64'd0);
        end
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_mid release no rsp", 64'(rsp_valid1), 64'd0);
        chk("rst_mid release cmd_ready", 64'(cmd_ready1), 64'd1);
        chk("rst_mid release cyc", 64'(wb1.CYC_O), 64'd0);

        run_vec(10, vecs[0]);
        run_vec(11, vecs[5]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
- Synthesizable, parametrised Wishbone classic master replacing the behavioural bench master in bench and in-system test harnesses.
- Accepts single or incrementing-burst read/write commands on a valid/ready port, streams write data in and read data out, and drives Wishbone with CYC held across the whole burst.
- Adds bounded RTY re-issue, a bus timeout, and a per-command completion status.

Parameters:
- AW, 32, address width.
- DW, 32, data width, multiple of 8. SW = DW/8 select lines (derived).
- LENW, 4, burst length field width; max burst 2^LENW beats.
- MAX_RETRY, 3, RTY re-issues allowed per beat before giving up.
- RETRY_GAP, 2, idle cycles (CYC_O low) before a retry, >=1.
- TIMEOUT, 64, cycles STB_O may stay high without ACK/ERR/RTY; 0 disables.

Ports:
- CLK_I in 1: clock, all logic on rising edge.
- RSTN_I in 1: asynchronous active-low reset.
- ADR_O out AW: byte address.
- DAT_O out DW: write data.
- DAT_I in DW: read data.
- SEL_O out SW: byte selects.
- CYC_O out 1: bus cycle.
- STB_O out 1: strobe.
- WE_O out 1: write enable.
- ACK_I in 1: acknowledge.
- ERR_I in 1: error.
- RTY_I in 1: retry.
- cmd_valid in 1: command present.
- cmd_ready out 1: command accepted when cmd_valid & cmd_ready.
- cmd_we in 1: 1 = write.
- cmd_adr in AW: start address.
- cmd_len in LENW: beats minus 1.
- wdat_valid in 1: write beat present.
- wdat_ready out 1: write beat accepted when both high.
- wdat in DW: write data.
- wsel in SW: write selects.
- rdat_valid out 1: one-cycle pulse per read beat, no backpressure.
- rdat out DW: read data.
- rsp_valid out 1: one-cycle completion pulse.
- rsp_status out 2: 00 OK, 01 ERR, 10 RTY exhausted, 11 TIMEOUT.
- rsp_count out LENW+1: beats acknowledged.

Behaviour:
- Reset: RSTN_I low clears all outputs immediately, regardless of CLK_I; all outputs and counters 0, state IDLE.
- Reset mid-burst drops CYC_O/STB_O at once with no rsp_valid.
- All outputs are registered.
- FSM states: IDLE, WDATA, STROBE, GAP, RETRY, DONE.
- IDLE:
  - cmd_ready=1. On accept, latch address, length and we.
  - Read: STROBE next cycle.
  - Write: WDATA next cycle.
  - CYC_O=1 from the first cycle after accept.
- WDATA:
  - wdat_ready=1, CYC_O=1, STB_O=0.
  - On accept, register wdat/wsel into DAT_O/SEL_O and go to STROBE.
- STROBE:
  - STB_O=1, WE_O=we. SEL_O is all-ones for reads, latched wsel for writes.
  - Termination priority when inputs coincide: ERR_I > RTY_I > ACK_I.
  - ACK_I: count++; read beats register rdat=DAT_I with rdat_valid pulsing the next cycle.
  - After ACK, if beats remain: GAP (read) or WDATA (write), and ADR_O += SW, wrapping modulo 2^AW.
  - After ACK on the last beat: DONE.
- GAP: exactly one cycle with STB_O=0 and CYC_O=1, then STROBE.
- Beat spacing: every beat has at least one cycle between STB_O falling and rising again; CYC_O stays high across the burst.
- ERR_I: CYC_O/STB_O drop next cycle; DONE with status 01, count = beats acked before the error.
- RTY_I:
  - CYC_O/STB_O drop next cycle; per-beat retry counter++.
  - If counter <= MAX_RETRY: RETRY for RETRY_GAP cycles, then CYC_O/STB_O reassert with the same ADR_O/DAT_O/SEL_O.
  - Otherwise DONE with status 10.
  - Retry counter clears on every ACK.
- Timeout:
  - Counter runs while in STROBE and clears on any termination.
  - When it reaches TIMEOUT: drop CYC_O/STB_O, DONE with status 11.
- DONE:
  - CYC_O=0, STB_O=0, rsp_valid=1 for one cycle, then IDLE.
  - For reads, rsp_valid coincides with or follows the last rdat_valid.
  - cmd_ready is 0 during DONE.
- cmd_ready is 0 whenever the state is not IDLE.

Test Plan:
- Single read: cmd adr=0x100, len=0; slave ACKs second STB cycle returning 0xDEADBEEF. Required: rdat_valid once with 0xDEADBEEF, rsp_status=00, rsp_count=1, CYC_O high for exactly the strobe span plus setup.
- Burst write: 4 beats at 0x1000 with data 0x11..0x44 and wsel=4'hF, wdat_valid gaps of 3 cycles. Required: ADR_O 0x1000, 0x1004, 0x1008, 0x100C; CYC_O continuous; rsp_count=4, status 00.
- Retry: RTY_I on beat 2 twice, then ACK. Required: two GAP/RETRY sequences with identical ADR_O/DAT_O; status 00, count 4. With MAX_RETRY=1, the second RTY gives status 10, count 1.
- Error and priority: ERR_I together with ACK_I on beat 3 of a 4-beat read. Required: ERR wins; status 01, count 2; no rdat_valid for beat 3.
- Timeout and wrap: slave never responds with TIMEOUT=8. Required: STB_O high 8 cycles, then status 11, count 0. A 2-beat read at 0xFFFFFFFC must issue ADR_O 0x00000000 on beat 2.
- Reset mid-burst: RSTN_I low between clock edges during beat 2. Required: CYC_O/STB_O low immediately; no rsp_valid; after release, cmd_ready=1 and a new command runs normally.
